// File: rtl/pipeline_pkg.sv
// Shared pipeline constants and helpers used by the IF and ID stages.
package pipeline_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 32;

  // sll $0,$0,0
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [ADDR_W-1:0]  RESET_PC  = 32'h0000_0000;

  // Signed word offset of a branch, turned into a byte offset.
  function automatic logic [ADDR_W-1:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with hold (stall) and bubble (flush) control.
module if_id_reg #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hold,
  input  logic        flush,
  input  logic [31:0] fetch_instr,
  input  logic [31:0] fetch_pc4,
  output logic [31:0] instr,
  output logic [31:0] pc4,
  output logic        valid
);

  logic [31:0] instr_q, pc4_q;
  logic        valid_q;

  // Reset beats hold, hold beats flush, flush beats a normal load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_q <= NOP_INSTR;
      pc4_q   <= 32'h0;
      valid_q <= 1'b0;
    end else if (hold) begin
      instr_q <= instr_q;
      pc4_q   <= pc4_q;
      valid_q <= valid_q;
    end else if (flush) begin
      instr_q <= NOP_INSTR;
      pc4_q   <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= fetch_instr;
      pc4_q   <= fetch_pc4;
      valid_q <= 1'b1;
    end
  end

  assign instr = instr_q;
  assign pc4   = pc4_q;
  assign valid = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC sequencing, branch/jump redirect with
// squash of the wrong-path fetch, and fetch/squash performance counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = pipeline_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = pipeline_pkg::NOP_INSTR,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic [31:0]          imem_addr,
  input  logic [31:0]          imem_rdata,
  input  logic                 stall,
  input  logic                 branch_taken,
  input  logic [15:0]          branch_imm,
  input  logic                 jump,
  input  logic [25:0]          jump_index,
  output logic [31:0]          if_id_instr,
  output logic [31:0]          if_id_pc4,
  output logic                 if_id_valid,
  output logic [CNT_WIDTH-1:0] fetch_count,
  output logic [CNT_WIDTH-1:0] squash_count
);

  import pipeline_pkg::*;

  logic [31:0]          pc_q, pc_d, pc4, br_target, j_target;
  logic                 do_jump, do_branch, redirect, fetch;
  logic [CNT_WIDTH-1:0] fetch_count_q, squash_count_q;

  // Next-PC selection; redirects only count when ID holds a real instruction.
  always_comb begin
    pc4       = pc_q + 32'd4;
    br_target = if_id_pc4 + branch_offset(branch_imm);
    j_target  = {if_id_pc4[31:28], jump_index, 2'b00};
    do_jump   = !stall && jump && if_id_valid;
    do_branch = !stall && branch_taken && if_id_valid && !jump;
    redirect  = do_jump || do_branch;
    fetch     = !stall && !redirect;
    pc_d      = pc_q;
    if (do_jump) begin
      pc_d = j_target;
    end else if (do_branch) begin
      pc_d = br_target;
    end else if (fetch) begin
      pc_d = pc4;
    end
  end

  // PC register and performance counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q           <= RESET_PC;
      fetch_count_q  <= '0;
      squash_count_q <= '0;
    end else begin
      pc_q <= pc_d;
      if (fetch) begin
        fetch_count_q <= fetch_count_q + CNT_WIDTH'(1);
      end
      if (redirect) begin
        squash_count_q <= squash_count_q + CNT_WIDTH'(1);
      end
    end
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .hold        (stall),
    .flush       (redirect),
    .fetch_instr (imem_rdata),
    .fetch_pc4   (pc4),
    .instr       (if_id_instr),
    .pc4         (if_id_pc4),
    .valid       (if_id_valid)
  );

  assign imem_addr    = pc_q;
  assign fetch_count  = fetch_count_q;
  assign squash_count = squash_count_q;

endmodule
